// File: rtl/mem_arbiter.sv
// Two-requester external memory bus arbiter and fixed-length cycle sequencer.
// Requester 0 is the control fetch port and requester 1 is the data/store port.
// Simultaneous requests are granted round-robin. Every output is a flop.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [7:0]           wdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [7:0]           wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [7:0]           rdata,
    output logic                 grant,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] addr_bus,
    output logic [7:0]           mem_wdata,
    output logic                 mem_wdata_oe,
    input  logic [7:0]           mem_rdata,
    output logic                 read_en,
    output logic                 write_en
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 we_q, we_d;
    logic                 grant_q, grant_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic [WORD_SIZE-1:0] addr_bus_q, addr_bus_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 mem_wdata_oe_q, mem_wdata_oe_d;
    logic                 read_en_q, read_en_d;
    logic                 write_en_q, write_en_d;
    logic                 win;
    logic                 win_we;

    // Next-state and next-output logic; outputs are computed for the coming state.
    // The address and write-data output flops also act as the latched request.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        we_d           = we_q;
        grant_d        = grant_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        rdata_d        = rdata_q;
        busy_d         = busy_q;
        addr_bus_d     = addr_bus_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wdata_oe_d = mem_wdata_oe_q;
        read_en_d      = read_en_q;
        write_en_d     = write_en_q;
        win            = (req0 && req1) ? ~last_grant_q : req1;
        win_we         = win ? we1 : we0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d        = ACCESS;
                    grant_d        = win;
                    we_d           = win_we;
                    addr_bus_d     = win ? addr1 : addr0;
                    mem_wdata_d    = win ? wdata1 : wdata0;
                    cnt_d          = CNT_W'(WAIT_STATES);
                    read_en_d      = ~win_we;
                    write_en_d     = win_we;
                    mem_wdata_oe_d = win_we;
                    busy_d         = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d        = DONE;
                    read_en_d      = 1'b0;
                    write_en_d     = 1'b0;
                    mem_wdata_oe_d = 1'b0;
                    ack0_d         = ~grant_q;
                    ack1_d         = grant_q;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                last_grant_d = grant_q;
            end
            default: begin
                state_d        = IDLE;
                busy_d         = 1'b0;
                read_en_d      = 1'b0;
                write_en_d     = 1'b0;
                mem_wdata_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            we_q           <= 1'b0;
            grant_q        <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            rdata_q        <= '0;
            busy_q         <= 1'b0;
            addr_bus_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wdata_oe_q <= 1'b0;
            read_en_q      <= 1'b0;
            write_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            we_q           <= we_d;
            grant_q        <= grant_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            rdata_q        <= rdata_d;
            busy_q         <= busy_d;
            addr_bus_q     <= addr_bus_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wdata_oe_q <= mem_wdata_oe_d;
            read_en_q      <= read_en_d;
            write_en_q     <= write_en_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata        = rdata_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign addr_bus     = addr_bus_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wdata_oe = mem_wdata_oe_q;
    assign read_en      = read_en_q;
    assign write_en     = write_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait state and one with none.
// Both instances share the same stimulus.
module tb_mem_arbiter;

    logic        clk, reset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, mem_rdata;

    logic        ack0, ack1, grant, busy, mem_wdata_oe, read_en, write_en;
    logic [7:0]  rdata, mem_wdata;
    logic [15:0] addr_bus;

    logic        d0_ack0, d0_ack1, d0_grant, d0_busy, d0_oe, d0_read_en, d0_write_en;
    logic [7:0]  d0_rdata, d0_wdata;
    logic [15:0] d0_addr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.WORD_SIZE(16), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
        .addr_bus(addr_bus), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
        .mem_rdata(mem_rdata), .read_en(read_en), .write_en(write_en)
    );

    mem_arbiter #(.WORD_SIZE(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(d0_ack0), .ack1(d0_ack1), .rdata(d0_rdata), .grant(d0_grant), .busy(d0_busy),
        .addr_bus(d0_addr), .mem_wdata(d0_wdata), .mem_wdata_oe(d0_oe),
        .mem_rdata(mem_rdata), .read_en(d0_read_en), .write_en(d0_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then show the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({ack0, ack1, rdata, grant, busy, addr_bus, mem_wdata, mem_wdata_oe, read_en, write_en} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got ack=%b%b rdata=%h grant=%b busy=%b addr=%h wd=%h oe=%b re=%b we=%b, want all 0",
                              ack0, ack1, rdata, grant, busy, addr_bus, mem_wdata, mem_wdata_oe, read_en, write_en);
        end
    endtask

    task automatic test_read0();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; mem_rdata = 8'hA5;
        tick();
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if ({read_en, write_en, addr_bus, busy} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
                n_bad++; $display("FAIL read0_access%0d: re=%b we=%b addr=%h busy=%b, want 1 0 0010 1", c, read_en, write_en, addr_bus, busy);
            end
            n_cmp++; if ({ack0, ack1} !== 2'b00) begin
                n_bad++; $display("FAIL read0_early_ack%0d: got %b%b want 00", c, ack0, ack1);
            end
            if (c == 0) tick();
        end
        tick();
        n_cmp++; if ({ack0, ack1, read_en, rdata, grant} !== {1'b1, 1'b0, 1'b0, 8'hA5, 1'b0}) begin
            n_bad++; $display("FAIL read0_done: ack0=%b ack1=%b re=%b rdata=%h grant=%b, want 1 0 0 a5 0", ack0, ack1, read_en, rdata, grant);
        end
        req0 = 1'b0;
        tick();
        n_cmp++; if ({ack0, busy, rdata, addr_bus} !== {1'b0, 1'b0, 8'hA5, 16'h0010}) begin
            n_bad++; $display("FAIL read0_idle: ack0=%b busy=%b rdata=%h addr=%h, want 0 0 a5 0010", ack0, busy, rdata, addr_bus);
        end
    endtask

    task automatic test_write1();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h8001; wdata1 = 8'h3C; mem_rdata = 8'hEE;
        tick();
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if ({write_en, mem_wdata_oe, read_en, mem_wdata, addr_bus, grant} !== {1'b1, 1'b1, 1'b0, 8'h3C, 16'h8001, 1'b1}) begin
                n_bad++; $display("FAIL write1_access%0d: we=%b oe=%b re=%b wd=%h addr=%h grant=%b, want 1 1 0 3c 8001 1",
                                  c, write_en, mem_wdata_oe, read_en, mem_wdata, addr_bus, grant);
            end
            tick();
        end
        n_cmp++; if ({ack1, ack0, write_en, mem_wdata_oe, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_bad++; $display("FAIL write1_done: ack1=%b ack0=%b we=%b oe=%b rdata=%h, want 1 0 0 0 a5", ack1, ack0, write_en, mem_wdata_oe, rdata);
        end
        req1 = 1'b0; we1 = 1'b0;
        tick();
        n_cmp++; if ({ack1, busy} !== 2'b00) begin
            n_bad++; $display("FAIL write1_idle: ack1=%b busy=%b want 0 0", ack1, busy);
        end
    endtask

    task automatic test_ws0();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0033; mem_rdata = 8'hC3;
        tick();
        n_cmp++; if ({d0_read_en, d0_addr, d0_ack0} !== {1'b1, 16'h0033, 1'b0}) begin
            n_bad++; $display("FAIL ws0_access: re=%b addr=%h ack0=%b, want 1 0033 0", d0_read_en, d0_addr, d0_ack0);
        end
        tick();
        n_cmp++; if ({d0_read_en, d0_ack0, d0_rdata} !== {1'b0, 1'b1, 8'hC3}) begin
            n_bad++; $display("FAIL ws0_done: re=%b ack0=%b rdata=%h, want 0 1 c3", d0_read_en, d0_ack0, d0_rdata);
        end
        req0 = 1'b0;
        tick();
        n_cmp++; if ({d0_ack0, d0_busy} !== 2'b00) begin
            n_bad++; $display("FAIL ws0_idle: ack0=%b busy=%b want 0 0", d0_ack0, d0_busy);
        end
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        logic exp_g;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h1000; addr1 = 16'h2000;
        for (int k = 0; k < 4; k++) begin
            exp_g = 1'(k % 2);
            mem_rdata = 8'(8'h10 + k);
            tick();
            n_cmp++; if ({grant, read_en, addr_bus} !== {exp_g, 1'b1, (exp_g ? 16'h2000 : 16'h1000)}) begin
                n_bad++; $display("FAIL rr_grant%0d: grant=%b re=%b addr=%h, want grant=%b", k, grant, read_en, addr_bus, exp_g);
            end
            repeat (2) tick();
            n_cmp++; if ({ack0, ack1, grant, rdata} !== {~exp_g, exp_g, exp_g, 8'(8'h10 + k)}) begin
                n_bad++; $display("FAIL rr_ack%0d: ack0=%b ack1=%b grant=%b rdata=%h", k, ack0, ack1, grant, rdata);
            end
            tick();
            n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin
                n_bad++; $display("FAIL rr_idle%0d: ack0=%b ack1=%b busy=%b, want 000", k, ack0, ack1, busy);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0042; wdata0 = 8'h77;
        tick();
        tick();
        n_cmp++; if ({write_en, mem_wdata_oe, busy} !== 3'b111) begin
            n_bad++; $display("FAIL mid_second_access: we=%b oe=%b busy=%b want 111", write_en, mem_wdata_oe, busy);
        end
        #3 reset = 1'b1; req0 = 1'b0; we0 = 1'b0;
        #1;
        n_cmp++; if ({write_en, mem_wdata_oe, busy} !== 3'b000) begin
            n_bad++; $display("FAIL mid_async_drop: we=%b oe=%b busy=%b want 000", write_en, mem_wdata_oe, busy);
        end
        tick();
        n_cmp++; if ({ack0, ack1} !== 2'b00) begin
            n_bad++; $display("FAIL mid_no_ack: ack0=%b ack1=%b want 00", ack0, ack1);
        end
        reset = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005; mem_rdata = 8'h5A;
        tick();
        n_cmp++; if ({grant, read_en, addr_bus} !== {1'b1, 1'b1, 16'h0005}) begin
            n_bad++; $display("FAIL mid_regrant: grant=%b re=%b addr=%h want 1 1 0005", grant, read_en, addr_bus);
        end
        repeat (2) tick();
        n_cmp++; if ({ack1, rdata} !== {1'b1, 8'h5A}) begin
            n_bad++; $display("FAIL mid_reack: ack1=%b rdata=%h want 1 5a", ack1, rdata);
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_drop_req();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0100; addr1 = 16'h0200; mem_rdata = 8'h81;
        tick();
        n_cmp++; if ({grant, addr_bus} !== {1'b0, 16'h0100}) begin
            n_bad++; $display("FAIL drop_first_grant: grant=%b addr=%h want 0 0100", grant, addr_bus);
        end
        req0 = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({ack0, ack1, rdata} !== {1'b1, 1'b0, 8'h81}) begin
            n_bad++; $display("FAIL drop_ack0: ack0=%b ack1=%b rdata=%h want 1 0 81", ack0, ack1, rdata);
        end
        mem_rdata = 8'h82;
        repeat (2) tick();
        n_cmp++; if ({grant, read_en, addr_bus} !== {1'b1, 1'b1, 16'h0200}) begin
            n_bad++; $display("FAIL drop_second_grant: grant=%b re=%b addr=%h want 1 1 0200", grant, read_en, addr_bus);
        end
        req1 = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({ack1, ack0, rdata} !== {1'b1, 1'b0, 8'h82}) begin
            n_bad++; $display("FAIL drop_ack1: ack1=%b ack0=%b rdata=%h want 1 0 82", ack1, ack0, rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read0();
        test_write1();
        test_ws0();
        test_round_robin();
        test_reset_mid_access();
        test_drop_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port external memory bus arbiter and cycle sequencer for the CPU. It shares one external memory bus between requester 0 (instruction/operand fetch from control) and requester 1 (data/store port). It grants one requester at a time with round-robin on ties, runs a fixed-length read or write cycle including wait states, and returns read data with a one-cycle ack. The bidirectional data bus tristate lives at the cpu top level, driven from `mem_wdata`/`mem_wdata_oe`.

## Interface
- `WORD_SIZE`, 16, address width.
- `WAIT_STATES`, 1, extra access cycles beyond the first; legal range 0..15.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; returns the block to IDLE.
- `req0` in 1: requester 0 access request; held high until `ack0`.
- `we0` in 1: requester 0 access type; 1 = write, 0 = read.
- `addr0` in WORD_SIZE: requester 0 address.
- `wdata0` in 8: requester 0 write data.
- `req1`, `we1`, `addr1`, `wdata1`: same as the requester 0 signals, for requester 1.
- `ack0`, `ack1` out 1: one-cycle completion pulse to the granted requester.
- `rdata` out 8: captured read data, shared by both requesters; valid while ack is high and held until the next read completes.
- `grant` out 1: index of the current or most recent owner.
- `busy` out 1: high in ACCESS and DONE.
- `addr_bus` out WORD_SIZE: memory address.
- `mem_wdata` out 8: write data to memory.
- `mem_wdata_oe` out 1: top-level data bus drive enable.
- `mem_rdata` in 8: read data from memory.
- `read_en`, `write_en` out 1: memory strobes; never both high at once.

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: memory cycle in progress.
  - DONE: completion cycle.
- IDLE, no request: stay in IDLE with all strobes low.
- IDLE, exactly one `reqN` high: grant N.
- IDLE, both requests high: grant the requester not in `last_grant`, then go to ACCESS.
- On grant, register the winner's addr, we and wdata into internal latches, and load the wait counter with WAIT_STATES. Requester inputs are ignored until the next IDLE.
- ACCESS drives:
  - `addr_bus` = latched address.
  - Read: `read_en` = 1.
  - Write: `write_en` = 1, `mem_wdata_oe` = 1, `mem_wdata` = latched data.
- ACCESS counter: decrement each cycle. The edge that finds the counter at 0 moves to DONE. On a read, that same edge also captures `mem_rdata` into `rdata`.
- DONE:
  - Strobes and `mem_wdata_oe` low.
  - `ack[grant]` = 1.
  - `last_grant` <= grant.
  - Next state IDLE, unconditionally.
- A request still high in the IDLE cycle after DONE is a new request.
- Requester drops `req` during ACCESS: the cycle still completes and ack still pulses. No abort.
- `addr_bus` holds its last value in IDLE and DONE.
- `grant` holds the last owner.

## Timing
- Reset values:
  - state IDLE.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - All outputs 0: `ack0`, `ack1`, `rdata`, `grant`, `busy`, `addr_bus`, `mem_wdata`, `mem_wdata_oe`, `read_en`, `write_en`.
- Reset asserted mid-access: strobes drop immediately (asynchronously). No ack is issued. The request is lost; the requester re-requests.
- Latency, with edge E being the one that samples `req` in IDLE:
  - ACCESS occupies cycles E+1 .. E+1+WAIT_STATES.
  - ack is high in cycle E+2+WAIT_STATES.
  - The earliest next grant edge is E+3+WAIT_STATES.
- Throughput: one access per WAIT_STATES+3 cycles.
- Strobe width: exactly WAIT_STATES+1 cycles.
- Address and write data are stable for the whole strobe.
- All outputs are registered; no combinational path from `req` to ack or strobes.

## Test plan
- WAIT_STATES=1, `req0` read at 0x0010, `mem_rdata`=0xA5: `read_en` high 2 cycles with `addr_bus`=0x0010; `ack0` high 1 cycle at E+3; `rdata`=0xA5; `ack1` stays 0.
- `req1` write 0x3C to 0x8001: `write_en` and `mem_wdata_oe` high 2 cycles, `mem_wdata`=0x3C, `read_en` 0 throughout; `ack1` pulses once at E+3.
- After reset, `req0` and `req1` both high continuously, both reads: grants alternate 0,1,0,1; one ack every 4 cycles; `grant` matches the acked port.
- WAIT_STATES=0, single read: `read_en` high exactly 1 cycle; ack at E+2.
- Reset asserted in the 2nd ACCESS cycle of a write: `write_en`, `mem_wdata_oe` and `busy` go 0 before the next edge; no ack; next request after reset is granted normally.
- Requester 0 drops `req0` during ACCESS while `req1` is pending: `ack0` still pulses; requester 1 is granted on the following IDLE edge.
